// File: rtl/fp32_pkg.sv
// Shared binary32 definitions: op encodings, field layout, canonical values and the round/pack helper.
// FP32_ROUND_NEAREST_EN selects round-to-nearest-even in round_pack; otherwise results truncate toward zero.
package fp32_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;
  localparam logic [31:0] NEG_INF  = 32'hFF800000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef struct packed {
    logic        ovf;
    logic        unf;
    logic [31:0] word;
  } rnd_t;

  // exp is the biased exponent of a significand already normalised to 1.man
  function automatic rnd_t round_pack(input logic sign, input logic signed [9:0] exp,
                                      input logic [22:0] man, input logic g, input logic r,
                                      input logic s);
    rnd_t             res;
    logic             rne;
    logic             inc;
    logic [23:0]      man_r;
    logic signed [9:0] exp_r;
    rne = g & (r | s | man[0]);
`ifdef FP32_ROUND_NEAREST_EN
    inc = rne;
`else
    inc = rne & 1'b0;
`endif
    man_r = {1'b0, man} + {23'd0, inc};
    exp_r = exp + (man_r[23] ? 10'sd1 : 10'sd0);
    res   = '0;
    if (exp_r > 10'sd254) begin
      res.ovf  = 1'b1;
      res.word = sign ? NEG_INF : POS_INF;
    end else if (exp_r < 10'sd1) begin
      res.unf  = 1'b1;
      res.word = {sign, 31'd0};
    end else begin
      res.word = {sign, exp_r[7:0], man_r[22:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// Leading-zero counter for add/sub normalisation; returns WIDTH when the input is all zeros.
module fp32_lzc #(
  parameter int WIDTH = 25,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CW-1:0]    cnt_o
);

  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp32_arith_unit.sv
// binary32 add/sub/mul/compare, one op per cycle, results registered one cycle later; no backpressure.
// FP32_ROUND_NEAREST_EN switches add/sub/mul rounding from truncation to round-to-nearest-even.
module fp32_arith_unit
  import fp32_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [1:0]   op,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  output logic         out_valid,
  output logic [W-1:0] result,
  output logic         greater,
  output logic         exception,
  output logic         overflow,
  output logic         underflow
);

  if (W != 32) begin : g_bad_width
    $error("fp32_arith_unit supports W=32 only");
  end

  fp32_t a_f, b_f;
  op_e   op_s;
  logic  a_zero, b_zero, exc;

  assign a_f    = a_operand;
  assign b_f    = b_operand;
  assign op_s   = op_e'(op);
  assign a_zero = (a_f.exp == 8'd0);
  assign b_zero = (b_f.exp == 8'd0);
  assign exc    = (a_f.exp == EXP_MAX) || (b_f.exp == EXP_MAX);

  // Add/sub: order by magnitude, align smaller with 3 guard bits (G, R, sticky)
  logic        b_sign_eff, a_ge, sign_l, eff_sub, sticky;
  logic [7:0]  exp_l, exp_s, exp_diff;
  logic [22:0] man_l, man_s;
  logic [26:0] sig_l, sig_s, sig_sh, sig_al;
  logic [27:0] sum;

  always_comb begin
    b_sign_eff = b_f.sign ^ (op_s == OP_SUB);
    a_ge       = {a_f.exp, a_f.man} >= {b_f.exp, b_f.man};
    sign_l     = a_ge ? a_f.sign : b_sign_eff;
    exp_l      = a_ge ? a_f.exp  : b_f.exp;
    exp_s      = a_ge ? b_f.exp  : a_f.exp;
    man_l      = a_ge ? a_f.man  : b_f.man;
    man_s      = a_ge ? b_f.man  : a_f.man;
    eff_sub    = a_f.sign ^ b_sign_eff;
    exp_diff   = exp_l - exp_s;
    sig_l      = {1'b1, man_l, 3'b000};
    sig_s      = {1'b1, man_s, 3'b000};
    if (exp_diff >= 8'd27) begin
      sig_sh = 27'd0;
      sticky = 1'b1;
    end else begin
      sig_sh = sig_s >> exp_diff;
      sticky = |(sig_s & ((27'd1 << exp_diff) - 27'd1));
    end
    sig_al = {sig_sh[26:1], sig_sh[0] | sticky};
    sum    = eff_sub ? ({1'b0, sig_l} - {1'b0, sig_al}) : ({1'b0, sig_l} + {1'b0, sig_al});
  end

  logic [4:0] lz;

  fp32_lzc #(.WIDTH(25)) u_lzc (
    .vec_i (sum[26:2]),
    .cnt_o (lz)
  );

  logic [26:0]       norm;
  logic signed [9:0] exp_n;
  rnd_t              add_rnd;
  logic [31:0]       add_word;
  logic              add_ovf, add_unf;

  always_comb begin
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, exp_l}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, exp_l}) - $signed({5'd0, lz});
    end
    add_rnd  = round_pack(sign_l, exp_n, norm[25:3], norm[2], norm[1], norm[0]);
    add_word = add_rnd.word;
    add_ovf  = add_rnd.ovf;
    add_unf  = add_rnd.unf;
    if (b_zero) begin
      add_word = a_zero ? {a_f.sign, 31'd0} : a_f;
      add_ovf  = 1'b0;
      add_unf  = 1'b0;
    end else if (a_zero) begin
      add_word = {b_sign_eff, b_f.exp, b_f.man};
      add_ovf  = 1'b0;
      add_unf  = 1'b0;
    end else if (!sum[27] && lz == 5'd25) begin
      add_word = 32'd0;
      add_ovf  = 1'b0;
      add_unf  = 1'b0;
    end
  end

  // Multiply: product of 1.x significands lies in [1,4), so at most a 1-bit normalise
  logic [47:0]       prod;
  logic signed [9:0] exp_m;
  logic              sign_m;
  rnd_t              mul_rnd;

  assign prod   = {1'b1, a_f.man} * {1'b1, b_f.man};
  assign sign_m = a_f.sign ^ b_f.sign;
  assign exp_m  = $signed({2'b00, a_f.exp}) + $signed({2'b00, b_f.exp}) - 10'(EXP_BIAS);

  always_comb begin
    if (prod[47])
      mul_rnd = round_pack(sign_m, exp_m + 10'sd1, prod[46:24], prod[23], prod[22], |prod[21:0]);
    else
      mul_rnd = round_pack(sign_m, exp_m, prod[45:23], prod[22], prod[21], |prod[20:0]);
  end

  // Compare: map sign-magnitude onto two's complement so both zeros collapse to 0
  logic [30:0]        mag_a, mag_b;
  logic signed [31:0] key_a, key_b;

  assign mag_a = a_zero ? 31'd0 : {a_f.exp, a_f.man};
  assign mag_b = b_zero ? 31'd0 : {b_f.exp, b_f.man};
  assign key_a = a_f.sign ? -$signed({1'b0, mag_a}) : $signed({1'b0, mag_a});
  assign key_b = b_f.sign ? -$signed({1'b0, mag_b}) : $signed({1'b0, mag_b});

  logic        out_valid_q;
  logic [31:0] result_q, result_d;
  logic        greater_q, greater_d, exception_q, exception_d;
  logic        overflow_q, overflow_d, underflow_q, underflow_d;

  always_comb begin
    result_d    = result_q;
    greater_d   = greater_q;
    exception_d = exception_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (in_valid) begin
      greater_d   = 1'b0;
      exception_d = exc;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (op_s == OP_CMP) begin
        result_d  = 32'd0;
        greater_d = !exc && (key_a > key_b);
      end else if (exc) begin
        result_d = QNAN;
      end else if (op_s == OP_MUL) begin
        if (a_zero || b_zero) begin
          result_d = {sign_m, 31'd0};
        end else begin
          result_d    = mul_rnd.word;
          overflow_d  = mul_rnd.ovf;
          underflow_d = mul_rnd.unf;
        end
      end else begin
        result_d    = add_word;
        overflow_d  = add_ovf;
        underflow_d = add_unf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      greater_q   <= 1'b0;
      exception_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      result_q    <= result_d;
      greater_q   <= greater_d;
      exception_q <= exception_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign greater   = greater_q;
  assign exception = exception_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fp32_arith_unit.sv
// Directed-vector bench for fp32_arith_unit with hand-computed binary32 expectations.
module tb_fp32_arith_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a_operand, b_operand;
  logic        out_valid;
  logic [31:0] result;
  logic        greater, exception, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, CMP = 2'b11;
`ifdef FP32_ROUND_NEAREST_EN
  localparam logic [31:0] EXP_SMALL_ADD = 32'h3F800001;
`else
  localparam logic [31:0] EXP_SMALL_ADD = 32'h3F800000;
`endif

  fp32_arith_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .result    (result),
    .greater   (greater),
    .exception (exception),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Order: out_valid, greater, exception, overflow, underflow
  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk({tag, ".flags"}, {27'd0, out_valid, greater, exception, overflow, underflow},
        {27'd0, exp});
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op        = o;
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 2'b00;
    a_operand = 32'd0;
    b_operand = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.result", result, 32'h0);
    chk_flags("reset", 5'b00000);
    reset = 1'b0;

    issue(ADD, 32'h3F800000, 32'h40000000);
    chk("add_1_2", result, 32'h40400000);
    chk_flags("add_1_2", 5'b10000);
    idle();
    chk("add_1_2.hold", result, 32'h40400000);
    chk_flags("add_1_2.idle", 5'b00000);

    issue(SUB, 32'h3F800000, 32'h40000000);
    chk("sub_1_2", result, 32'hBF800000);
    issue(SUB, 32'h40400000, 32'h40400000);
    chk("sub_cancel", result, 32'h00000000);
    chk_flags("sub_cancel", 5'b10000);
    issue(ADD, 32'h40000000, 32'hBF000000);
    chk("add_2_m0p5", result, 32'h3FC00000);
    issue(ADD, 32'h3F800000, 32'h33C00000);
    chk("add_small_round", result, EXP_SMALL_ADD);
    issue(ADD, 32'h00000000, 32'h40A00000);
    chk("add_zero_pass", result, 32'h40A00000);

    issue(MUL, 32'h3FC00000, 32'h3FC00000);
    chk("mul_1p5_sq", result, 32'h40100000);
    chk_flags("mul_1p5_sq", 5'b10000);
    issue(MUL, 32'h7F000000, 32'h7F000000);
    chk("mul_ovf", result, 32'h7F800000);
    chk_flags("mul_ovf", 5'b10010);

    for (int i = 0; i < 3; i++) begin
      idle();
      chk("hold.result", result, 32'h7F800000);
      chk_flags("hold", 5'b00010);
    end

    issue(MUL, 32'h00800000, 32'h00800000);
    chk("mul_unf", result, 32'h00000000);
    chk_flags("mul_unf", 5'b10001);
    issue(MUL, 32'hC0000000, 32'h00000000);
    chk("mul_zero", result, 32'h80000000);
    chk_flags("mul_zero", 5'b10000);

    issue(CMP, 32'h40000000, 32'h3F800000);
    chk("cmp_2_1.result", result, 32'h0);
    chk_flags("cmp_2_1", 5'b11000);
    issue(CMP, 32'hBF800000, 32'h3F000000);
    chk_flags("cmp_m1_0p5", 5'b10000);
    issue(CMP, 32'h3F000000, 32'hBF800000);
    chk_flags("cmp_0p5_m1", 5'b11000);
    issue(CMP, 32'hC0000000, 32'hBF800000);
    chk_flags("cmp_m2_m1", 5'b10000);
    issue(CMP, 32'h80000000, 32'h00000000);
    chk_flags("cmp_negzero", 5'b10000);
    issue(CMP, 32'h3F800000, 32'h3F800000);
    chk_flags("cmp_equal", 5'b10000);

    issue(ADD, 32'h7F800000, 32'h3F800000);
    chk("exc_add", result, 32'h7FC00000);
    chk_flags("exc_add", 5'b10100);

    issue(ADD, 32'h3F800000, 32'h40000000);
    chk("pre_reset", result, 32'h40400000);
    reset = 1'b1;
    issue(MUL, 32'h7F000000, 32'h7F000000);
    chk("reset_vs_valid.result", result, 32'h0);
    chk_flags("reset_vs_valid", 5'b00000);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset.result", result, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
